// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic intersection blocks: controller state
// constants, the sensor conditioner FSM encoding and default parameters.
package traffic_pkg;

  // Traffic controller light-phase states.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } ctrl_state_e;

  // Sensor conditioner FSM states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEB_ON  = 3'd1,
    ACTIVE  = 3'd2,
    DEB_OFF = 3'd3,
    HOLD    = 3'd4
  } cond_state_e;

  // Default parameter values for sensor_conditioner.
  localparam int DEF_DEB_CYCLES  = 4;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_CNT_W       = 8;

  // Counter widths sized for the legal parameter ranges (1..15, 1..255).
  localparam int DEB_W  = 4;
  localparam int HOLD_W = 8;

  // A car is reported present in every state past the arrival debounce.
  function automatic logic sensor_level(input cond_state_e s);
    return (s == ACTIVE) || (s == DEB_OFF) || (s == HOLD);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for bringing an asynchronous level into
// the clk domain. Only the second flop is visible to the outside.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the raw level through two flops; the first may go metastable.
  // NOTE: non-blocking assignments let r_sync capture the old r_meta value;
  // blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions a bouncing, asynchronous car-detector level into a clean
// registered car-present level, a one-cycle arrival pulse and a saturating
// arrival counter. After a qualified arrival the present level is held for
// at least HOLD_CYCLES cycles so a car pausing over the loop is not lost.
module sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_raw,
  input  logic             cnt_clr,
  output logic             sensor,
  output logic             arrival,
  output logic [CNT_W-1:0] arrival_cnt
);

  localparam logic [DEB_W-1:0]  DEB_LIM  = DEB_W'(DEB_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic              w_sync;
  cond_state_e       r_state;
  cond_state_e       w_state_next;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [DEB_W-1:0]  w_deb_cnt_next;
  logic [DEB_W-1:0]  w_deb_run;
  logic              w_deb_done;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_next;
  logic [HOLD_W-1:0] w_hold_dec;
  logic              w_hold_expired;
  logic              w_arrival_next;
  logic              r_sensor;
  logic              r_arrival;
  logic [CNT_W-1:0]  r_arrival_cnt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (sensor_raw),
    .o_q (w_sync)
  );

  // Length of the current run of samples opposing the reported level,
  // including this one: a run starts at 1 in the stable states.
  always_comb begin
    w_deb_run = DEB_W'(1);
    if ((r_state == DEB_ON) || (r_state == DEB_OFF)) begin
      w_deb_run = r_deb_cnt + DEB_W'(1);
    end
  end

  assign w_deb_done     = (w_deb_run == DEB_LIM);
  assign w_hold_dec     = (r_hold_cnt == '0) ? '0 : r_hold_cnt - HOLD_W'(1);
  assign w_hold_expired = (w_hold_dec == '0);

  // Next-state, debounce/hold counter and arrival-pulse decode.
  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_next    = r_state;
    w_deb_cnt_next  = r_deb_cnt;
    w_hold_cnt_next = (r_state == IDLE) ? r_hold_cnt : w_hold_dec;
    w_arrival_next  = 1'b0;

    case (r_state)
      IDLE, DEB_ON: begin
        if (!w_sync) begin
          w_state_next   = IDLE;
          w_deb_cnt_next = '0;
        end else if (w_deb_done) begin
          w_state_next    = ACTIVE;
          w_deb_cnt_next  = '0;
          w_hold_cnt_next = HOLD_LIM;
          w_arrival_next  = 1'b1;
        end else begin
          w_state_next   = DEB_ON;
          w_deb_cnt_next = w_deb_run;
        end
      end

      ACTIVE, DEB_OFF: begin
        if (w_sync) begin
          // Car still (or again) present: no new arrival, hold keeps running.
          w_state_next   = ACTIVE;
          w_deb_cnt_next = '0;
        end else if (w_deb_done) begin
          w_state_next   = w_hold_expired ? IDLE : HOLD;
          w_deb_cnt_next = '0;
        end else begin
          w_state_next   = DEB_OFF;
          w_deb_cnt_next = w_deb_run;
        end
      end

      HOLD: begin
        // A returning car takes priority so the level never blinks low.
        if (w_sync) begin
          w_state_next = ACTIVE;
        end else if (w_hold_expired) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next    = IDLE;
        w_deb_cnt_next  = '0;
        w_hold_cnt_next = '0;
      end
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_deb_cnt  <= '0;
      r_hold_cnt <= '0;
      r_sensor   <= 1'b0;
      r_arrival  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_deb_cnt  <= w_deb_cnt_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_sensor   <= sensor_level(w_state_next);
      r_arrival  <= w_arrival_next;
    end
  end

  // Saturating arrival counter; a clear beats a simultaneous arrival.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arrival_cnt <= '0;
    end else if (cnt_clr) begin
      r_arrival_cnt <= '0;
    end else if (r_arrival && (r_arrival_cnt != CNT_MAX)) begin
      r_arrival_cnt <= r_arrival_cnt + CNT_W'(1);
    end
  end

  assign sensor      = r_sensor;
  assign arrival     = r_arrival;
  assign arrival_cnt = r_arrival_cnt;

endmodule
